fc_vec_loader: RTL and testbench
================================

# fc_vec_loader

Sequential front/back end for the combinational fully-connected `layer` neuron. It accepts activations as a serial valid/ready word stream and assembles them into the parallel `x[0:IN-1]` vector that drives the layer. It holds that vector stable for a programmable settle window, samples the layer's ReLU output `z`, and returns the result on a valid/ready output stream. One instance sits between the activation buffer and each `layer` instance.

## Interface
Parameters:
- `WIDTH`, 8, activation word width; matches the layer's `WIDTH`.
- `IN`, 128, vector length; matches the layer's `IN`.
- `OUT_W`, 23, result width; matches the layer output width `WIDTH*2+$clog2(terms)`.
- `SETTLE`, 2, cycles the vector is held before `z` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  WIDTH  activation word.
- `s_last`  in  1  marks the last word of a vector.
- `x`  out  WIDTH × [0:IN-1]  unpacked vector to the layer; registered.
- `z`  in  OUT_W  layer result; combinational from `x`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  OUT_W  captured result.
- `frame_err`  out  1  one-cycle pulse on a malformed vector length.

## Operation
- FSM states: LOAD, SETTLE, OUT.
- **LOAD**
  - `s_ready` = 1 (combinational from state).
  - On each handshake, `x[idx] <= s_data` and `idx <= idx+1`; `idx` is `$clog2(IN)` bits wide.
  - The vector ends on the first handshake where `s_last`=1 or `idx`==IN-1. The FSM then moves to SETTLE and loads `cnt <= SETTLE-1`.
  - Entries not written in a vector stay 0, because `x` is cleared at vector start.
- **frame_err**: pulses 1 in the cycle after the ending handshake if either:
  - `s_last`=1 with `idx`<IN-1 (short vector), or
  - `idx`==IN-1 with `s_last`=0 (missing last).
  - The vector is still processed in both cases.
- **SETTLE**
  - `s_ready` = 0 and `x` is held.
  - `cnt` decrements each cycle.
  - In the cycle `cnt`==0: `m_data <= z`, `m_valid <= 1`, state goes to OUT.
- **OUT**
  - `s_ready` = 0; `x`, `m_data` and `m_valid` are held.
  - On `m_valid && m_ready`: `m_valid <= 0`, all `x <= 0`, `idx <= 0`, state goes to LOAD.
- **Widths**: `m_data` is a straight copy of `z`, with no sign extension or truncation. The layer's ReLU already guarantees `z` ≥ 0.
- **`s_valid` while `s_ready`=0**: ignored. The upstream is required to hold the word per valid/ready rules.

## Timing
- **Reset values**: state=LOAD, `idx`=0, `cnt`=0, all `x`=0, `m_valid`=0, `m_data`=0, `frame_err`=0.
- **`s_ready` around reset**: 0 during any cycle `rst`=1; 1 in the first cycle after `rst` deasserts.
- **Latency**: ending handshake at edge t means:
  - SETTLE occupies cycles t+1 … t+SETTLE;
  - `z` is sampled at the end of cycle t+SETTLE;
  - `m_valid`=1 from cycle t+SETTLE+1.
- **`x` stability**: unchanged from the edge after the final word until the edge of the output handshake. The layer path is constrained as a SETTLE-cycle multicycle path.
- **Next vector**: the first word can be accepted in the cycle after the output handshake. Back-to-back throughput is IN + SETTLE + 1 cycles per vector with `m_ready` held high.
- **Reset mid-operation** (any state): the in-flight vector and any pending result are discarded; no `m_valid` and no `frame_err` are produced for it.
- **Simultaneous `s_last` and `idx`==IN-1**: a normal end, no error.

## Test plan
- **Full vector, no stalls**: `x[i]`=i+1 for i=0..127, `s_last` on word 127, `SETTLE`=2, layer stubbed so `z`=sum(x) mod 2^23 → `m_valid` rises exactly 3 cycles after the last handshake, `m_data`=8256, `frame_err` stays 0.
- **Backpressure**: `s_valid` toggled 1/0 during load, `m_ready`=0 for 5 cycles after `m_valid` → `m_data` and `x` stay constant, `s_ready`=0 throughout, result accepted on the 6th cycle, `s_ready`=1 on the next.
- **Short vector**: `s_last` on word 10 (`idx`=9), data 0x7F → `frame_err` pulses once, `x[0..9]`=0x7F, `x[10..127]`=0, result emitted normally.
- **Missing last**: 128 words with `s_last`=0 → `frame_err` pulses, `s_ready` drops right after word 128, word 129 is not accepted until the output handshake.
- **Reset mid-load**: `rst` asserted after 50 words → next cycle all `x`=0, `idx`=0, `m_valid`=0; a fresh 128-word vector then completes normally.
- **Back-to-back**: two vectors, `m_ready`=1 constantly → second-vector words start the cycle after the first output handshake, `x` reads all 0 before the first new word, both results are correct.

Source files
------------

// File: rtl/fc_vec_loader_if.sv
// Serial activation input stream and result output stream of the vector loader.
// The slave modport is the loader's view; master is the upstream/downstream view.
interface fc_vec_loader_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 23
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/fc_vec_loader.sv
// Assembles a serial activation stream into the parallel layer vector, holds it
// for a settle window, samples the layer result and returns it on a stream.
module fc_vec_loader #(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int OUT_W  = 23,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    fc_vec_loader_if.slave   bus,
    output logic [WIDTH-1:0] x [0:IN-1],
    input  logic [OUT_W-1:0] z,
    output logic             frame_err
);
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_OUT} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [3:0]       cnt_reg;
    logic             m_valid_reg;
    logic [OUT_W-1:0] m_data_reg;
    logic             frame_err_reg;
    logic [WIDTH-1:0] x_reg [0:IN-1];

    logic s_ready_c;
    logic s_hs;
    logic m_hs;
    logic is_last_idx;
    logic vec_end;

    assign s_hs        = bus.s_valid && s_ready_c;
    assign m_hs        = (state_reg == S_OUT) && m_valid_reg && bus.m_ready;
    assign is_last_idx = (idx_reg == IDX_LAST);
    assign vec_end     = s_hs && (bus.s_last || is_last_idx);

    always_comb begin
        state_next = state_reg;
        s_ready_c  = 1'b0;
        case (state_reg)
            S_LOAD: begin
                // Held low while reset is asserted so no word is taken mid-reset.
                s_ready_c = !rst;
                if (vec_end) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_reg == 4'd0) state_next = S_OUT;
            end
            S_OUT: begin
                if (m_hs) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_LOAD;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            cnt_reg       <= '0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            // Error when the length counter and s_last disagree on where the vector ends.
            frame_err_reg <= vec_end && (bus.s_last != is_last_idx);
            if (s_hs) idx_reg <= idx_reg + IDX_W'(1);
            if (vec_end) cnt_reg <= CNT_INIT;
            if (state_reg == S_SETTLE) begin
                cnt_reg <= cnt_reg - 4'd1;
                if (cnt_reg == 4'd0) begin
                    m_data_reg  <= z;
                    m_valid_reg <= 1'b1;
                end
            end
            if (m_hs) begin
                m_valid_reg <= 1'b0;
                idx_reg     <= '0;
            end
        end
    end

    // Vector is cleared on output handshake so short vectors leave zeros behind.
    generate
        for (genvar gi = 0; gi < IN; gi++) begin : g_x
            always_ff @(posedge clk) begin
                if (rst || m_hs)
                    x_reg[gi] <= '0;
                else if (s_hs && (idx_reg == IDX_W'(gi)))
                    x_reg[gi] <= bus.s_data;
            end
        end
    endgenerate

    assign x           = x_reg;
    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_data  = m_data_reg;
    assign frame_err   = frame_err_reg;
endmodule

// File: tb/tb_fc_vec_loader.sv
// Directed bench for fc_vec_loader with a summing stub in place of the layer.
module tb_fc_vec_loader;
    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int OUT_W  = 23;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_vec_loader_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();
    logic [WIDTH-1:0] x [0:IN-1];
    logic [OUT_W-1:0] z;
    logic             frame_err;

    fc_vec_loader #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .x         (x),
        .z         (z),
        .frame_err (frame_err)
    );

    // Layer stub: sum of the vector modulo 2^OUT_W.
    always_comb begin
        z = '0;
        for (int i = 0; i < IN; i++) z = z + OUT_W'(x[i]);
    end

    int checks = 0;
    int fails  = 0;
    int err_pulses = 0;

    always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

    typedef struct {
        string       name;
        int          len;
        bit          last;
        bit          ramp;
        logic [7:0]  val;
        bit          gap;
        int          hold;
        bit          exp_err;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] word_of(input vec_t v, input int i);
        logic [7:0] w;
        w = v.ramp ? 8'(i + 1) : v.val;
        return w;
    endfunction

    function automatic int x_nonzero();
        int n = 0;
        for (int i = 0; i < IN; i++) if (x[i] !== '0) n++;
        return n;
    endfunction

    task automatic send_word(input logic [7:0] d, input logic last);
        int w = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus.s_ready) check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_m_valid(input string name, output int lat);
        lat = 1;
        while (!bus.m_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.m_valid) check({name, "_m_valid_timeout"}, 32'(bus.m_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat, bad;
        logic [OUT_W-1:0] held;
        bus.m_ready = (v.hold == 0);
        for (int i = 0; i < v.len; i++) begin
            send_word(word_of(v, i), v.last && (i == v.len - 1));
            if (v.gap && i != v.len - 1) tick();
        end
        check({v.name, "_frame_err"}, 32'(frame_err), 32'(v.exp_err));
        check({v.name, "_s_ready_settle"}, 32'(bus.s_ready), 32'd0);
        bad = 0;
        for (int i = 0; i < IN; i++)
            if (x[i] !== ((i < v.len) ? word_of(v, i) : 8'd0)) bad++;
        check({v.name, "_x_bad_entries"}, 32'(bad), 32'd0);
        wait_m_valid(v.name, lat);
        check({v.name, "_latency"}, 32'(lat), 32'(SETTLE + 1));
        check({v.name, "_m_data"}, 32'(bus.m_data), v.exp_sum);
        held = bus.m_data;
        for (int k = 0; k < v.hold; k++) begin
            bad = 0;
            for (int i = 0; i < IN; i++)
                if (x[i] !== ((i < v.len) ? word_of(v, i) : 8'd0)) bad++;
            check({v.name, "_hold_x"}, 32'(bad), 32'd0);
            check({v.name, "_hold_m_data"}, 32'(bus.m_data), 32'(held));
            check({v.name, "_hold_s_ready"}, 32'(bus.s_ready), 32'd0);
            check({v.name, "_hold_m_valid"}, 32'(bus.m_valid), 32'd1);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        check({v.name, "_s_ready_after"}, 32'(bus.s_ready), 32'd1);
        check({v.name, "_m_valid_after"}, 32'(bus.m_valid), 32'd0);
        check({v.name, "_x_cleared"}, 32'(x_nonzero()), 32'd0);
        $display("vec %s len=%0d m_data=%0d latency=%0d", v.name, v.len, held, lat);
    endtask

    initial begin
        int lat;
        tbl[0] = '{"full_ramp",  128, 1'b1, 1'b1, 8'h00, 1'b0, 0, 1'b0, 32'd8256};
        tbl[1] = '{"backpress",  128, 1'b1, 1'b0, 8'h02, 1'b1, 5, 1'b0, 32'd256};
        tbl[2] = '{"short",       10, 1'b1, 1'b0, 8'h7F, 1'b0, 0, 1'b1, 32'd1270};
        tbl[3] = '{"full_ff",    128, 1'b1, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 32'd32640};
        tbl[4] = '{"single",       1, 1'b1, 1'b0, 8'h05, 1'b0, 0, 1'b1, 32'd5};

        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        tick();
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_x", 32'(x_nonzero()), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

        for (int r = 0; r < 5; r++) run_vec(tbl[r]);

        // Missing last: 128 words without s_last, word 129 held until output handshake.
        bus.m_ready = 1'b0;
        for (int i = 0; i < IN; i++) send_word(8'h01, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        bus.s_last  = 1'b1;
        check("miss_frame_err", 32'(frame_err), 32'd1);
        check("miss_s_ready", 32'(bus.s_ready), 32'd0);
        wait_m_valid("miss", lat);
        check("miss_latency", 32'(lat), 32'(SETTLE + 1));
        check("miss_m_data", 32'(bus.m_data), 32'd128);
        tick();
        check("miss_s_ready_out", 32'(bus.s_ready), 32'd0);
        check("miss_m_valid_held", 32'(bus.m_valid), 32'd1);
        bus.m_ready = 1'b1;
        tick();
        check("miss_s_ready_after", 32'(bus.s_ready), 32'd1);
        check("miss_x_cleared", 32'(x_nonzero()), 32'd0);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("w129_frame_err", 32'(frame_err), 32'd1);
        check("w129_x0", 32'(x[0]), 32'h33);
        wait_m_valid("w129", lat);
        check("w129_m_data", 32'(bus.m_data), 32'd51);
        tick();
        check("w129_s_ready_after", 32'(bus.s_ready), 32'd1);
        $display("vec missing_last+w129 m_data=51 expected, frame_err pulses so far=%0d", err_pulses);

        // Reset in the middle of a load discards the partial vector.
        for (int i = 0; i < 50; i++) send_word(8'(i + 1), 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        tick();
        check("midrst_x", 32'(x_nonzero()), 32'd0);
        check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_s_ready_after", 32'(bus.s_ready), 32'd1);
        $display("vec mid_load_reset after 50 words");
        run_vec(tbl[0]);

        tick();
        tick();
        check("frame_err_pulse_total", 32'(err_pulses), 32'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
